// File: rtl/cpu_program_sequencer.sv
// ============================================================================
//  Module      : cpu_program_sequencer
//  Description : Instruction store and run controller for the 8-bit CPU core.
//                Loads a program byte-by-byte, releases the core from reset,
//                feeds one instruction per enabled cycle indexed by the core
//                PC, and provides halt / single-step / breakpoint control.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                load_*              - program byte stream (valid/ready)
//                run_start, halt_req, step_req, abort - run control
//                brk_en, brk_addr    - breakpoint on core PC
//                cpu_pc              - core program counter (store index)
//                cpu_rst, cpu_step, instr - core reset, clock enable, opcode
//                state, prog_len, cycle_count, done - status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_program_sequencer #(
    parameter int          DEPTH  = 16,
    parameter int          ADDR_W = 4,
    parameter int          CNT_W  = 16,
    parameter logic [7:0]  FILL   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              run_start,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              abort,
    input  logic              brk_en,
    input  logic [7:0]        brk_addr,
    input  logic [7:0]        cpu_pc,
    output logic              cpu_rst,
    output logic              cpu_step,
    output logic [7:0]        instr,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   prog_len,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    wptr_q, wptr_d;
    logic [ADDR_W:0]    prog_len_q, prog_len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               first_q, first_d;     // RUN entry cycle: core reset edge
    logic               supp_q, supp_d;       // breakpoint masked on resume cycle
    logic               post_rst_q, post_rst_d;

    logic [7:0]         mem [DEPTH];

    logic               w_xfer;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [ADDR_W:0]    w_wnext;
    logic               w_pc_ok;
    logic               w_brk;
    logic [7:0]         w_rd;

    assign w_xfer  = load_valid & load_ready & ~abort;
    assign w_wnext = wptr_q + 1'b1;
    assign w_pc_ok = cpu_pc < 8'(prog_len_q);
    assign w_brk   = brk_en & (cpu_pc == brk_addr) & ~supp_q;
    assign w_rd    = mem[cpu_pc[ADDR_W-1:0]];

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        prog_len_d = prog_len_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        first_d    = 1'b0;
        supp_d     = 1'b0;
        post_rst_d = 1'b0;
        w_we       = 1'b0;
        w_waddr    = '0;
        cpu_rst    = 1'b0;
        cpu_step   = 1'b0;
        instr      = FILL;
        load_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) & ~post_rst_q;

        case (state_q)
            ST_IDLE: begin
                cpu_rst = 1'b1;
                if (abort) begin
                    wptr_d = '0;
                end else if (w_xfer) begin
                    w_we    = 1'b1;
                    w_waddr = '0;
                    if (load_last) begin
                        prog_len_d = (ADDR_W+1)'(1);
                        wptr_d     = '0;
                    end else begin
                        state_d = ST_LOAD;
                        wptr_d  = (ADDR_W+1)'(1);
                    end
                end else if (run_start && (prog_len_q != '0)) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end

            ST_LOAD: begin
                cpu_rst = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                    wptr_d  = '0;
                end else if (w_xfer) begin
                    w_we    = 1'b1;
                    w_waddr = wptr_q[ADDR_W-1:0];
                    if (load_last || (w_wnext == (ADDR_W+1)'(DEPTH))) begin
                        prog_len_d = w_wnext;
                        wptr_d     = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        wptr_d = w_wnext;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    cpu_rst = 1'b1;
                    state_d = ST_IDLE;
                    wptr_d  = '0;
                end else if (first_q) begin
                    // Core is enabled while held in reset so it resets on this edge.
                    cpu_rst  = 1'b1;
                    cpu_step = 1'b1;
                end else if (halt_req || w_brk) begin
                    state_d = ST_HALT;
                end else if (w_pc_ok) begin
                    cpu_step = 1'b1;
                    instr    = w_rd;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_HALT;
                end
            end

            default: begin // ST_HALT
                if (abort) begin
                    cpu_rst = 1'b1;
                    state_d = ST_IDLE;
                    wptr_d  = '0;
                end else if (run_start && !done_q) begin
                    state_d = ST_RUN;
                    supp_d  = 1'b1;
                end else if (step_req && !done_q) begin
                    if (w_pc_ok) begin
                        cpu_step = 1'b1;
                        instr    = w_rd;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
        endcase

        if (cpu_step && !cpu_rst && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            prog_len_q <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            first_q    <= 1'b0;
            supp_q     <= 1'b0;
            post_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            prog_len_q <= prog_len_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            first_q    <= first_d;
            supp_q     <= supp_d;
            post_rst_q <= post_rst_d;
        end
    end

    // Store has no reset; contents are only read below prog_len.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_waddr] <= load_data;
        end
    end

    assign state       = state_q;
    assign prog_len    = prog_len_q;
    assign cycle_count = cnt_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_program_sequencer.sv
// ============================================================================
//  Module      : tb_cpu_program_sequencer
//  Description : Self-checking bench for cpu_program_sequencer: directed
//                vector table, a long program load, then randomized cycles
//                checked against a behavioural model of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_program_sequencer;

    logic        clk = 1'b0;
    logic        rst, load_valid, load_last, run_start, halt_req, step_req, abort, brk_en;
    logic [7:0]  load_data, brk_addr, cpu_pc;
    logic        load_ready, cpu_rst, cpu_step, done;
    logic [7:0]  instr;
    logic [1:0]  state;
    logic [4:0]  prog_len;
    logic [15:0] cycle_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_program_sequencer #(.DEPTH(16), .ADDR_W(4), .CNT_W(16), .FILL(8'h00)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .run_start(run_start), .halt_req(halt_req), .step_req(step_req), .abort(abort),
        .brk_en(brk_en), .brk_addr(brk_addr), .cpu_pc(cpu_pc),
        .cpu_rst(cpu_rst), .cpu_step(cpu_step), .instr(instr), .state(state),
        .prog_len(prog_len), .cycle_count(cycle_count), .done(done)
    );

    typedef struct {
        bit rst, lv; bit [7:0] ld; bit ll, rs, hr, sr, ab, be; bit [7:0] ba, pc;
        bit chk, lr, crst, cstep; bit [7:0] instr; bit [1:0] st; bit dn; bit [4:0] plen; bit [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(bit r, bit lv, bit [7:0] ld, bit ll, bit rs, bit hr, bit sr, bit ab,
                                bit be, bit [7:0] ba, bit [7:0] pc, bit c, bit lr, bit crst, bit cs,
                                bit [7:0] ins, bit [1:0] st, bit dn, bit [4:0] pl, bit [15:0] cnt);
        vec_t v;
        v.rst = r; v.lv = lv; v.ld = ld; v.ll = ll; v.rs = rs; v.hr = hr; v.sr = sr; v.ab = ab;
        v.be = be; v.ba = ba; v.pc = pc; v.chk = c; v.lr = lr; v.crst = crst; v.cstep = cs;
        v.instr = ins; v.st = st; v.dn = dn; v.plen = pl; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Modes: 0 idle, 1 loading, 2 running, 3 halted.
    int  m_mode, m_wp, m_len, m_cnt;
    bit  m_done, m_first, m_supp, m_post;
    int  m_mem [16];
    bit  e_lr, e_rst, e_step;
    int  e_instr;

    task automatic m_eval();
        bit in_range, hit;
        in_range = int'(cpu_pc) < m_len;
        hit      = brk_en && (cpu_pc == brk_addr) && !m_supp;
        e_lr     = (m_mode <= 1) && !m_post;
        e_rst    = (m_mode <= 1) || m_first || abort;
        e_step   = 1'b0;
        if (!abort && m_mode == 2) e_step = m_first ? 1'b1 : (!halt_req && !hit && in_range);
        if (!abort && m_mode == 3) e_step = step_req && !run_start && !m_done && in_range;
        e_instr  = (e_step && !m_first) ? m_mem[int'(cpu_pc) % 16] : 0;
    endtask

    task automatic m_commit();
        bit in_range, hit, was_first;
        in_range  = int'(cpu_pc) < m_len;
        hit       = brk_en && (cpu_pc == brk_addr) && !m_supp;
        was_first = m_first;
        if (rst) begin
            m_mode = 0; m_wp = 0; m_len = 0; m_cnt = 0;
            m_done = 0; m_first = 0; m_supp = 0; m_post = 1;
            return;
        end
        m_post = 0; m_first = 0; m_supp = 0;
        if (e_step && !e_rst && m_cnt < 65535) m_cnt++;
        if (abort) begin
            m_mode = 0; m_wp = 0;
        end else if (m_mode == 0) begin
            if (load_valid && e_lr) begin
                m_mem[0] = load_data;
                if (load_last) m_len = 1;
                else begin m_mode = 1; m_wp = 1; end
            end else if (run_start && m_len != 0) begin
                m_mode = 2; m_first = 1; m_cnt = 0; m_done = 0;
            end
        end else if (m_mode == 1) begin
            if (load_valid && e_lr) begin
                m_mem[m_wp] = load_data;
                m_wp++;
                if (load_last || m_wp == 16) begin m_len = m_wp; m_wp = 0; m_mode = 0; end
            end
        end else if (m_mode == 2) begin
            if (!was_first) begin
                if (halt_req || hit) m_mode = 3;
                else if (!in_range) begin m_done = 1; m_mode = 3; end
            end
        end else begin
            if (run_start && !m_done) begin m_mode = 2; m_supp = 1; end
            else if (step_req && !m_done && !in_range) m_done = 1;
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; load_valid = v.lv; load_data = v.ld; load_last = v.ll; run_start = v.rs;
        halt_req = v.hr; step_req = v.sr; abort = v.ab; brk_en = v.be; brk_addr = v.ba; cpu_pc = v.pc;
    endtask

    task automatic check_model();
        chk("load_ready", load_ready, e_lr);
        chk("cpu_rst", cpu_rst, e_rst);
        chk("cpu_step", cpu_step, e_step);
        chk("instr", instr, e_instr);
        chk("state", state, m_mode);
        chk("done", done, m_done);
        chk("prog_len", prog_len, m_len);
        chk("cycle_count", cycle_count, m_cnt);
    endtask

    // One clock: apply inputs, check mid-cycle, model follows the edge.
    task automatic apply(input vec_t v, input bit use_tbl);
        drive(v);
        @(negedge clk);
        m_eval();
        if (use_tbl) begin
            if (v.chk) begin
                chk("tbl_load_ready", load_ready, v.lr);
                chk("tbl_cpu_rst", cpu_rst, v.crst);
                chk("tbl_cpu_step", cpu_step, v.cstep);
                chk("tbl_instr", instr, v.instr);
                chk("tbl_state", state, v.st);
                chk("tbl_done", done, v.dn);
                chk("tbl_prog_len", prog_len, v.plen);
                chk("tbl_cycle_count", cycle_count, v.cnt);
            end
        end else begin
            check_model();
        end
        @(posedge clk);
        m_commit();
        #1;
    endtask

    vec_t tbl [48];

    initial begin
        vec_t v;
        //               r lv ld    ll rs hr sr ab be ba pc   c lr rs st ins   st dn pl cnt
        tbl[0]  = mk(1,0,8'h00,0,0,0,0,0,0,0,0, 0,0,0,0,8'h00,0,0,0,0);
        tbl[1]  = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,0,1,0,8'h00,0,0,0,0);
        tbl[2]  = mk(0,0,8'h00,0,1,0,0,0,0,0,0, 1,1,1,0,8'h00,0,0,0,0);
        tbl[3]  = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,1,1,0,8'h00,0,0,0,0);
        tbl[4]  = mk(0,1,8'h11,0,0,0,0,0,0,0,0, 1,1,1,0,8'h00,0,0,0,0);
        tbl[5]  = mk(0,1,8'h22,0,0,0,0,0,0,0,0, 1,1,1,0,8'h00,1,0,0,0);
        tbl[6]  = mk(0,1,8'h33,1,0,0,0,0,0,0,0, 1,1,1,0,8'h00,1,0,0,0);
        tbl[7]  = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,1,1,0,8'h00,0,0,3,0);
        tbl[8]  = mk(0,0,8'h00,0,1,0,0,0,0,0,0, 1,1,1,0,8'h00,0,0,3,0);
        tbl[9]  = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,0,1,1,8'h00,2,0,3,0);
        tbl[10] = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,0,0,1,8'h11,2,0,3,0);
        tbl[11] = mk(0,0,8'h00,0,0,0,0,0,0,0,1, 1,0,0,1,8'h22,2,0,3,1);
        tbl[12] = mk(0,0,8'h00,0,0,0,0,0,0,0,2, 1,0,0,1,8'h33,2,0,3,2);
        tbl[13] = mk(0,0,8'h00,0,0,0,0,0,0,0,3, 1,0,0,0,8'h00,2,0,3,3);
        tbl[14] = mk(0,0,8'h00,0,0,0,0,0,0,0,3, 1,0,0,0,8'h00,3,1,3,3);
        tbl[15] = mk(0,0,8'h00,0,0,0,0,1,0,0,3, 1,0,1,0,8'h00,3,1,3,3);
        tbl[16] = mk(0,0,8'h00,0,1,0,0,0,1,1,0, 1,1,1,0,8'h00,0,1,3,3);
        tbl[17] = mk(0,0,8'h00,0,0,0,0,0,1,1,0, 1,0,1,1,8'h00,2,0,3,0);
        tbl[18] = mk(0,0,8'h00,0,0,0,0,0,1,1,0, 1,0,0,1,8'h11,2,0,3,0);
        tbl[19] = mk(0,0,8'h00,0,0,0,0,0,1,1,1, 1,0,0,0,8'h00,2,0,3,1);
        tbl[20] = mk(0,0,8'h00,0,0,0,0,0,1,1,1, 1,0,0,0,8'h00,3,0,3,1);
        tbl[21] = mk(0,0,8'h00,0,1,0,0,0,1,1,1, 1,0,0,0,8'h00,3,0,3,1);
        tbl[22] = mk(0,0,8'h00,0,0,0,0,0,1,1,1, 1,0,0,1,8'h22,2,0,3,1);
        tbl[23] = mk(0,0,8'h00,0,0,0,0,0,1,1,2, 1,0,0,1,8'h33,2,0,3,2);
        tbl[24] = mk(0,0,8'h00,0,0,0,0,0,1,1,3, 1,0,0,0,8'h00,2,0,3,3);
        tbl[25] = mk(0,0,8'h00,0,0,0,0,0,0,0,3, 1,0,0,0,8'h00,3,1,3,3);
        tbl[26] = mk(0,0,8'h00,0,0,0,0,1,0,0,3, 1,0,1,0,8'h00,3,1,3,3);
        tbl[27] = mk(0,0,8'h00,0,1,0,0,0,0,0,0, 1,1,1,0,8'h00,0,1,3,3);
        tbl[28] = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,0,1,1,8'h00,2,0,3,0);
        tbl[29] = mk(0,0,8'h00,0,0,1,0,0,0,0,0, 1,0,0,0,8'h00,2,0,3,0);
        tbl[30] = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,0,0,0,8'h00,3,0,3,0);
        tbl[31] = mk(0,0,8'h00,0,0,0,1,0,0,0,0, 1,0,0,1,8'h11,3,0,3,0);
        tbl[32] = mk(0,0,8'h00,0,0,0,0,0,0,0,1, 1,0,0,0,8'h00,3,0,3,1);
        tbl[33] = mk(0,0,8'h00,0,0,0,1,0,0,0,1, 1,0,0,1,8'h22,3,0,3,1);
        tbl[34] = mk(0,0,8'h00,0,0,0,0,0,0,0,2, 1,0,0,0,8'h00,3,0,3,2);
        tbl[35] = mk(0,0,8'h00,0,0,0,0,1,0,0,2, 1,0,1,0,8'h00,3,0,3,2);
        tbl[36] = mk(0,1,8'hAA,0,0,0,0,0,0,0,0, 1,1,1,0,8'h00,0,0,3,2);
        tbl[37] = mk(0,1,8'hBB,0,0,0,0,0,0,0,0, 1,1,1,0,8'h00,1,0,3,2);
        tbl[38] = mk(0,0,8'h00,0,0,0,0,1,0,0,0, 1,1,1,0,8'h00,1,0,3,2);
        tbl[39] = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,1,1,0,8'h00,0,0,3,2);
        tbl[40] = mk(0,0,8'h00,0,1,0,0,0,0,0,0, 1,1,1,0,8'h00,0,0,3,2);
        tbl[41] = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,0,1,1,8'h00,2,0,3,0);
        tbl[42] = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,0,0,1,8'hAA,2,0,3,0);
        tbl[43] = mk(1,0,8'h00,0,0,0,0,0,0,0,1, 1,0,0,1,8'hBB,2,0,3,1);
        tbl[44] = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,0,1,0,8'h00,0,0,0,0);
        tbl[45] = mk(0,1,8'h05,0,1,0,0,0,0,0,0, 1,1,1,0,8'h00,0,0,0,0);
        tbl[46] = mk(0,0,8'h00,0,0,0,0,0,0,0,0, 1,1,1,0,8'h00,1,0,0,0);
        tbl[47] = mk(0,0,8'h00,0,0,0,0,1,0,0,0, 1,1,1,0,8'h00,1,0,0,0);

        drive(tbl[0]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 48; i++) apply(tbl[i], 1'b1);

        // Long load with load_valid held and no last byte.
        for (int i = 0; i < 18; i++) begin
            v = mk(0,1,8'(8'h40 + i),0,0,0,0,0,0,0,0, 0,0,0,0,8'h00,0,0,0,0);
            apply(v, 1'b0);
            if (i == 15) begin
                chk("long_plen", prog_len, 16);
                chk("long_state_idle", state, 0);
            end
            if (i == 16) chk("long_restart_state", state, 1);
        end

        // Randomized cycles against the model.
        for (int n = 0; n < 3000; n++) begin
            v.rst = ($urandom % 150) == 0;
            v.lv  = ($urandom % 3) == 0;
            v.ld  = 8'($urandom);
            v.ll  = ($urandom % 4) == 0;
            v.rs  = ($urandom % 6) == 0;
            v.hr  = ($urandom % 12) == 0;
            v.sr  = ($urandom % 3) == 0;
            v.ab  = ($urandom % 60) == 0;
            v.be  = ($urandom % 2) == 0;
            v.ba  = 8'($urandom_range(0, 7));
            v.pc  = (($urandom % 10) == 0) ? 8'($urandom) : 8'($urandom_range(0, m_len + 1));
            apply(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_program_sequencer.md
Name: cpu_program_sequencer

Overview:
- Holds a small instruction store and sequences the 8-bit CPU core: loads a program, releases the core from reset, and feeds it one instruction per enabled cycle.
- Instruction indexing uses the core's PC.
- Provides halt, single-step and breakpoint control, so software-less bring-up and debug run from the chip pins.
- Sits between the pin interface and the core's instruction/reset inputs.

Parameters:
DEPTH, 16, number of instruction store entries (power of two)
ADDR_W, 4, log2(DEPTH); store index = cpu_pc[ADDR_W-1:0]
CNT_W, 16, width of executed-instruction counter
FILL, 8'h00, instruction value driven whenever no valid instruction is being issued

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
load_valid  in  1  load_data holds a program byte
load_data  in  8  program byte
load_last  in  1  qualifies final byte of program
load_ready  out  1  sequencer accepts a byte this cycle
run_start  in  1  start (IDLE) or resume (HALT)
halt_req  in  1  stop issuing instructions
step_req  in  1  execute one instruction while HALT
abort  in  1  return to IDLE, hold core in reset
brk_en  in  1  breakpoint enable
brk_addr  in  8  breakpoint PC
cpu_pc  in  8  core program counter
cpu_rst  out  1  reset to core
cpu_step  out  1  core clock enable: core advances on edges where high
instr  out  8  instruction to core
state  out  2  0 IDLE, 1 LOAD, 2 RUN, 3 HALT
prog_len  out  ADDR_W+1  loaded program length
cycle_count  out  CNT_W  instructions executed since run_start
done  out  1  program ran past its end

Behaviour:
- Reset (rst high at an edge): state IDLE, write pointer 0, prog_len 0, cycle_count 0, done 0. Store contents are undefined.
- Reset outputs: cpu_rst 1, cpu_step 0, instr FILL, load_ready 0 for the cycle after reset.
- Handshake: a byte transfers on an edge with load_valid & load_ready. load_ready = 1 in IDLE and LOAD, otherwise 0.
- IDLE:
  - A transfer writes the store at index 0 and goes to LOAD with write pointer 1.
  - A transfer with load_last set writes index 0, sets prog_len 1 and stays in IDLE.
  - A transfer takes priority over run_start in the same cycle; run_start is then ignored.
  - run_start with prog_len != 0 goes to RUN: cycle_count cleared, done cleared.
  - run_start with prog_len == 0 is ignored.
  - cpu_rst = 1 throughout IDLE and LOAD.
- LOAD:
  - Each transfer writes at the write pointer and increments it.
  - If load_last is set or the pointer reaches DEPTH: prog_len = pointer after write (1..DEPTH), pointer cleared, go to IDLE.
  - A byte offered while load_ready = 0 is not taken.
- RUN, first cycle after entry from IDLE: cpu_rst 1, cpu_step 1, instr FILL. The core sees reset on that edge.
- RUN, subsequent cycles: cpu_rst 0.
  - If cpu_pc < prog_len: instr = store[cpu_pc[ADDR_W-1:0]] combinationally, cpu_step 1.
  - Otherwise: cpu_step 0, instr FILL, done set, go to HALT.
- RUN exit priority, per cycle: abort > halt_req > breakpoint > end-of-program.
  - halt_req: cpu_step 0 that cycle, go to HALT.
  - Breakpoint (brk_en & cpu_pc == brk_addr, not on the reset cycle): cpu_step 0, go to HALT. The breakpointed instruction is not executed.
- HALT:
  - cpu_step 0 and instr FILL, except on a step cycle.
  - step_req with done 0 and cpu_pc < prog_len: cpu_step 1 for exactly that cycle, instr = store[cpu_pc]. Breakpoint is ignored for the stepped instruction.
  - A held step_req steps once per cycle.
  - step_req with pc out of range: sets done, no step.
  - run_start with done 0 resumes RUN without core reset. The breakpoint is suppressed for the first resumed cycle only, so a halted breakpoint can be passed.
  - run_start with done 1 is ignored.
- abort, from any state: go to IDLE next edge, cpu_rst 1, cpu_step 0. prog_len and store are retained; write pointer cleared. A partial LOAD is discarded, and prog_len keeps its previous value.
- cycle_count: +1 on every edge with cpu_step 1 and cpu_rst 0; saturates at all-ones. Not cleared by halt or abort.
- Outputs cpu_rst, cpu_step and instr are valid combinationally from state and cpu_pc within the same cycle. There is no added latency between cpu_pc and instr.

Test Plan:
- Load 3 bytes 0x11,0x22,0x33 (last on third) -> prog_len 3, state IDLE, load_ready 1. Hold load_valid with DEPTH+2 bytes and no last -> prog_len 16 after 16th, 17th accepted as a new program at index 0.
- run_start, drive cpu_pc 0,1,2,3 -> one reset cycle (cpu_rst 1, cpu_step 1), then instr 0x11,0x22,0x33 with cpu_step 1. At pc 3: cpu_step 0, done 1, state HALT, cycle_count 3.
- brk_en, brk_addr 1, run -> HALT with cpu_pc 1, cpu_step 0, instr 0x00. run_start -> instr 0x22 issued, continues to done.
- halt_req in RUN at pc 0 -> HALT. Two step_req pulses at pc 0 then 1 -> cpu_step high exactly 2 cycles with 0x11 then 0x22, cycle_count +2.
- abort during LOAD after 2 of 4 bytes -> IDLE, prog_len unchanged (3), cpu_rst 1. rst mid-RUN -> all outputs to reset values next cycle.
- run_start with prog_len 0 -> stays IDLE. load_valid and run_start together in IDLE -> byte taken, state LOAD.
